// File: rtl/sysid_verify_pkg.sv
// Shared types and constants for the system-ID boot check sequencer.
// State encoding, Avalon word addresses and counter widths.
package sysid_verify_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_REQ  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_REQ  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_CMP     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam int TMO_W = 16;
    localparam int RTY_W = 8;

    function automatic logic is_req(input state_t s);
        return (s == S_ID_REQ) || (s == S_TS_REQ);
    endfunction

    function automatic logic is_wait(input state_t s);
        return (s == S_ID_WAIT) || (s == S_TS_WAIT);
    endfunction

    function automatic logic is_busy(input state_t s);
        return is_req(s) || is_wait(s) || (s == S_CMP);
    endfunction

endpackage

// File: rtl/sysid_verify_seq.sv
// Boot-time sysid reader: fetches ID and timestamp over Avalon-MM,
// compares against expected values, with per-read timeout and retry.
module sysid_verify_seq
    import sysid_verify_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'hE097CBDC,
    parameter logic [31:0] EXPECTED_TS    = 32'h57628448,
    parameter int          CHECK_TS       = 1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic             CHK      = (CHECK_TS != 0);

    state_t           r_state;
    logic             r_avm_read;
    logic             r_avm_address;
    logic             r_busy;
    logic             r_done;
    logic             r_id_match;
    logic             r_ts_match;
    logic             r_timeout_err;
    logic [31:0]      r_id_value;
    logic [31:0]      r_ts_value;
    logic [TMO_W-1:0] r_tmo;
    logic [RTY_W-1:0] r_retry;

    state_t w_nstate;
    logic   w_accept;
    logic   w_in_txn;
    logic   w_tmo_hit;
    logic   w_retry_ok;
    logic   w_abort;
    logic   w_enter_req;
    logic   w_restart;

    always_comb begin
        w_nstate   = r_state;
        w_abort    = 1'b0;
        w_accept   = r_avm_read && !avm_waitrequest;
        w_in_txn   = is_req(r_state) || is_wait(r_state);
        w_tmo_hit  = w_in_txn && (r_tmo == TMO_LAST);
        w_retry_ok = (r_retry < RTY_MAX);
        w_restart  = (r_state == S_DONE) && start;
        // A completing handshake in the last allowed cycle still counts.
        unique case (r_state)
            S_IDLE: w_nstate = S_ID_REQ;
            S_ID_REQ: begin
                if (w_accept)
                    w_nstate = S_ID_WAIT;
                else if (w_tmo_hit)
                    w_abort = 1'b1;
            end
            S_ID_WAIT: begin
                if (avm_readdatavalid)
                    w_nstate = S_TS_REQ;
                else if (w_tmo_hit)
                    w_abort = 1'b1;
            end
            S_TS_REQ: begin
                if (w_accept)
                    w_nstate = S_TS_WAIT;
                else if (w_tmo_hit)
                    w_abort = 1'b1;
            end
            S_TS_WAIT: begin
                if (avm_readdatavalid)
                    w_nstate = S_CMP;
                else if (w_tmo_hit)
                    w_abort = 1'b1;
            end
            S_CMP: w_nstate = S_DONE;
            S_DONE: begin
                if (start)
                    w_nstate = S_ID_REQ;
            end
            default: w_nstate = S_IDLE;
        endcase
        if (w_abort)
            w_nstate = w_retry_ok ? S_ID_REQ : S_DONE;
        w_enter_req = is_req(w_nstate) &&
                      ((w_nstate != r_state) || w_abort);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_avm_read    <= 1'b0;
            r_avm_address <= ADDR_ID;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_id_match    <= 1'b0;
            r_ts_match    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
            r_tmo         <= '0;
            r_retry       <= '0;
        end else begin
            r_state <= w_nstate;
            r_busy  <= is_busy(w_nstate);
            r_done  <= (w_nstate == S_DONE);

            if (w_enter_req)
                r_tmo <= '0;
            else if (w_in_txn && (r_tmo != '1))
                r_tmo <= r_tmo + 1'b1;

            // After an abort the retry request restarts one cycle later,
            // so the aborted read is visibly dropped first.
            if (w_abort || w_accept)
                r_avm_read <= 1'b0;
            else if (w_enter_req)
                r_avm_read <= 1'b1;
            else if (is_req(r_state) && !r_avm_read)
                r_avm_read <= 1'b1;

            if (w_enter_req)
                r_avm_address <= (w_nstate == S_TS_REQ) ? ADDR_TS : ADDR_ID;

            if (w_restart)
                r_retry <= '0;
            else if (w_abort && w_retry_ok && (r_retry != '1))
                r_retry <= r_retry + 1'b1;

            if ((r_state == S_ID_WAIT) && avm_readdatavalid)
                r_id_value <= avm_readdata;
            if ((r_state == S_TS_WAIT) && avm_readdatavalid)
                r_ts_value <= avm_readdata;

            if (w_restart) begin
                r_id_match    <= 1'b0;
                r_ts_match    <= 1'b0;
                r_timeout_err <= 1'b0;
            end else if (r_state == S_CMP) begin
                r_id_match    <= (r_id_value == EXPECTED_ID);
                r_ts_match    <= !CHK || (r_ts_value == EXPECTED_TS);
                r_timeout_err <= 1'b0;
            end else if (w_abort && !w_retry_ok) begin
                r_id_match    <= 1'b0;
                r_ts_match    <= 1'b0;
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign avm_read    = r_avm_read;
    assign avm_address = r_avm_address;
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_match    = r_id_match;
    assign ts_match    = r_ts_match;
    assign timeout_err = r_timeout_err;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule
